// File: rtl/fnd_pkg.sv
// Shared definitions for the 4-digit FND scan controller.
// Holds the display constants, the scan FSM state type, the digit-index type
// and the active-low digit-select helper.
package fnd_pkg;

    localparam logic [3:0]  DIGIT_OFF   = 4'b1111;   // all digit anodes off
    localparam logic [3:0]  BCD_BLANK   = 4'hF;      // code the decoder renders dark
    localparam logic [13:0] MAX_DISPLAY = 14'd9999;  // largest value that fits four digits

    typedef enum logic {
        GAP = 1'b0,
        ON  = 1'b1
    } scan_state_t;

    typedef logic [1:0] digit_idx_t;

    // Active-low one-hot select for a digit index (0 -> 4'b1110, 3 -> 4'b0111).
    function automatic logic [3:0] digit_sel(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/fnd_scan_controller_bin_to_bcd.sv
// bin_to_bcd_seq: 14-bit sequential double-dabble binary-to-BCD converter.
// One input bit is consumed per clock, MSB first, over 14 busy cycles.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset (aborts a conversion)
//   i_start, i_bin   start request and the binary value captured with it
//   o_busy           registered, high for the 14 iteration cycles
//   o_done           high during the final iteration cycle
//   o_bcd_next       accumulator value after the current iteration; holds the
//                    finished 4-nibble result while o_done is high
module bin_to_bcd_seq (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [13:0] i_bin,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_bcd_next
);

    localparam logic [3:0] LAST_ITER = 4'd13;

    logic [13:0] r_shift;
    logic [15:0] r_acc;
    logic [3:0]  r_cnt;
    logic [15:0] w_adj;

    // Pre-shift correction: a nibble of 5 or more would reach 10+ when doubled.
    function automatic logic [3:0] f_add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    always_comb begin
        w_adj      = {f_add3(r_acc[15:12]), f_add3(r_acc[11:8]),
                      f_add3(r_acc[7:4]),   f_add3(r_acc[3:0])};
        o_bcd_next = {w_adj[14:0], r_shift[13]};
        o_done     = o_busy && (r_cnt == LAST_ITER);
    end

    // Control: iteration counter and busy flag
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_busy <= 1'b0;
            r_cnt  <= 4'd0;
        end else if (!o_busy) begin
            if (i_start) begin
                o_busy <= 1'b1;
                r_cnt  <= 4'd0;
            end
        end else begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == LAST_ITER) begin
                o_busy <= 1'b0;
            end
        end
    end

    // Datapath: input shifter and BCD accumulator
    always_ff @(posedge i_clk) begin
        if (!o_busy) begin
            if (i_start) begin
                r_shift <= i_bin;
                r_acc   <= 16'd0;
            end
        end else begin
            r_shift <= {r_shift[12:0], 1'b0};
            r_acc   <= o_bcd_next;
        end
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: drives one BCD-to-7-segment decoder across a 4-digit
// common-anode FND. Accepts a 14-bit value over a load handshake, converts it
// to BCD in the background and time-multiplexes the digits with a blank gap
// at the start of every slot and leading-zero suppression.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_value, i_load  value to display and its load request (ignored while busy)
//   o_busy           conversion in progress
//   o_ovf            last accepted value exceeded 9999 (display goes dark)
//   o_digit          active-low digit select, bit 0 = ones digit
//   o_bcd            BCD code of the selected digit, to the decoder value input
//   o_blank          1 blanks the decoder
module fnd_scan_controller #(
    parameter int TICK_DIV   = 100000,
    parameter int GAP_CYCLES = 1000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [13:0] i_value,
    input  logic        i_load,
    output logic        o_busy,
    output logic        o_ovf,
    output logic [3:0]  o_digit,
    output logic [3:0]  o_bcd,
    output logic        o_blank
);
    import fnd_pkg::*;

    localparam int            PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] GAP_END   = PW'(GAP_CYCLES);

    logic          w_accept;
    logic          w_done;
    logic [15:0]   w_bcd_next;
    logic          r_ovf_pend;
    logic [15:0]   r_digits;
    logic [3:0]    w_supp;

    scan_state_t   r_state;
    logic [PW-1:0] r_presc;
    digit_idx_t    r_idx;
    logic          w_wrap;
    logic [PW-1:0] w_presc_nxt;
    digit_idx_t    w_idx_nxt;

    // Leading-zero blanking for digits 3..1; the ones digit always shows.
    // Overflow digits are already BCD_BLANK, so suppression stays off there.
    function automatic logic [3:0] f_suppress(input logic [15:0] d, input logic ovf);
        logic s3, s2, s1;
        s3 = (d[15:12] == 4'd0);
        s2 = s3 && (d[11:8] == 4'd0);
        s1 = s2 && (d[7:4] == 4'd0);
        return ovf ? 4'b0000 : {s3, s2, s1, 1'b0};
    endfunction

    // Packs {o_digit, o_bcd, o_blank} for one slot position.
    function automatic logic [8:0] f_slot_out(input logic on, input digit_idx_t idx,
                                              input logic [15:0] d, input logic [3:0] supp);
        logic [3:0] bcd;
        bcd = d[{idx, 2'b00} +: 4];
        return on ? {digit_sel(idx), bcd, supp[idx]} : {DIGIT_OFF, bcd, 1'b1};
    endfunction

    assign w_accept = i_load && !o_busy;

    bin_to_bcd_seq u_bcd (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (w_accept),
        .i_bin      (i_value),
        .o_busy     (o_busy),
        .o_done     (w_done),
        .o_bcd_next (w_bcd_next)
    );

    // Load capture and digit register; digits and o_ovf change together on
    // the final conversion iteration.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ovf_pend <= 1'b0;
            r_digits   <= 16'd0;
            o_ovf      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ovf_pend <= (i_value > MAX_DISPLAY);
            end
            if (w_done) begin
                o_ovf    <= r_ovf_pend;
                r_digits <= r_ovf_pend ? {4{BCD_BLANK}} : w_bcd_next;
            end
        end
    end

    assign w_supp = f_suppress(r_digits, o_ovf);

    always_comb begin
        w_wrap      = (r_presc == TICK_LAST);
        w_presc_nxt = w_wrap ? '0 : r_presc + 1'b1;
        w_idx_nxt   = w_wrap ? r_idx + 2'd1 : r_idx;
    end

    // Scan FSM: outputs are registered from the next prescaler/index so they
    // line up with the slot position they describe.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= GAP;
            r_presc <= '0;
            r_idx   <= '0;
            o_digit <= DIGIT_OFF;
            o_bcd   <= 4'h0;
            o_blank <= 1'b1;
        end else begin
            r_presc <= w_presc_nxt;
            r_idx   <= w_idx_nxt;
            case (r_state)
                GAP: begin
                    if (w_presc_nxt >= GAP_END) begin
                        r_state <= ON;
                        {o_digit, o_bcd, o_blank} <= f_slot_out(1'b1, w_idx_nxt, r_digits, w_supp);
                    end else begin
                        {o_digit, o_bcd, o_blank} <= f_slot_out(1'b0, w_idx_nxt, r_digits, w_supp);
                    end
                end
                ON: begin
                    // With no gap configured the FSM stays in ON across slots.
                    if (w_wrap && (GAP_END != '0)) begin
                        r_state <= GAP;
                        {o_digit, o_bcd, o_blank} <= f_slot_out(1'b0, w_idx_nxt, r_digits, w_supp);
                    end else begin
                        {o_digit, o_bcd, o_blank} <= f_slot_out(1'b1, w_idx_nxt, r_digits, w_supp);
                    end
                end
                default: r_state <= GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Testbench for fnd_scan_controller (TICK_DIV = 8, GAP_CYCLES = 2).
// A reference model tracks the displayed decimal value and derives every
// scan output from the cycle count since reset.
module tb_fnd_scan_controller;

    localparam int TD  = 8;
    localparam int GAP = 2;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [13:0] i_value;
    logic        i_load;
    logic        o_busy, o_ovf, o_blank;
    logic [3:0]  o_digit, o_bcd;

    fnd_scan_controller #(.TICK_DIV(TD), .GAP_CYCLES(GAP)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_value (i_value),
        .i_load  (i_load),
        .o_busy  (o_busy),
        .o_ovf   (o_ovf),
        .o_digit (o_digit),
        .o_bcd   (o_bcd),
        .o_blank (o_blank)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int cyc;
    int m_val;
    bit m_ovf;
    bit pend_valid;
    int pend_a;
    int pend_v;
    int pow10 [4] = '{1, 10, 100, 1000};

    // slot capture for table vectors
    bit          cap_en = 0;
    logic [15:0] obs_bcd, obs_dig;
    logic [3:0]  obs_blank;
    bit          bcnt_en = 0;
    int          busy_cnt;

    typedef struct packed {
        logic [13:0] val;
        logic [15:0] bcd;
        logic [3:0]  blank;
        logic        ovf;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: sample mid-cycle, compare to the model, then drive.
    task automatic step(input bit ld, input int val);
        bit upd, e_busy, e_ovf, e_blank, on;
        int pos, idx, e_dig, e_bcd;
        @(negedge i_clk);
        upd    = pend_valid && (cyc == pend_a + 15);
        e_busy = pend_valid && (cyc > pend_a) && (cyc < pend_a + 15);
        e_ovf  = upd ? (pend_v > 9999) : m_ovf;
        pos    = cyc % TD;
        idx    = (cyc / TD) % 4;
        on     = (pos >= GAP);
        e_dig  = on ? (~(1 << idx)) & 15 : 15;
        e_bcd  = m_ovf ? 15 : (m_val / pow10[idx]) % 10;
        e_blank = on ? (!m_ovf && idx != 0 && m_val < pow10[idx]) : 1'b1;
        chk("busy", int'(o_busy), int'(e_busy));
        chk("ovf", int'(o_ovf), int'(e_ovf));
        chk("digit", int'(o_digit), e_dig);
        chk("blank", int'(o_blank), int'(e_blank));
        if (on) chk("bcd", int'(o_bcd), e_bcd);
        if (cap_en && pos == GAP) begin
            obs_bcd[idx*4 +: 4] = o_bcd;
            obs_dig[idx*4 +: 4] = o_digit;
            obs_blank[idx]      = o_blank;
        end
        if (bcnt_en && o_busy) busy_cnt++;
        if (upd) begin
            m_val      = pend_v;
            m_ovf      = (pend_v > 9999);
            pend_valid = 0;
        end
        i_load  = ld;
        i_value = 14'(val);
        if (ld && !e_busy) begin
            pend_valid = 1;
            pend_a     = cyc;
            pend_v     = val;
        end
        cyc++;
    endtask

    task automatic model_reset();
        cyc = 0; m_val = 0; m_ovf = 0; pend_valid = 0;
    endtask

    // Assert reset mid-cycle, check the asynchronous clear, release early in a cycle.
    task automatic do_reset();
        @(posedge i_clk);
        #2 i_reset = 1'b1;
        i_load = 1'b0;
        #1;
        chk("rst_digit", int'(o_digit), 15);
        chk("rst_bcd", int'(o_bcd), 0);
        chk("rst_blank", int'(o_blank), 1);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_ovf", int'(o_ovf), 0);
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
        model_reset();
    endtask

    initial begin
        i_reset = 1'b1;
        i_load  = 1'b0;
        i_value = 14'd0;
        vecs[0] = '{14'd1234,  16'h1234, 4'b0000, 1'b0};
        vecs[1] = '{14'd7,     16'h0007, 4'b1110, 1'b0};
        vecs[2] = '{14'd1005,  16'h1005, 4'b0000, 1'b0};
        vecs[3] = '{14'd12000, 16'hFFFF, 4'b0000, 1'b1};
        vecs[4] = '{14'd9999,  16'h9999, 4'b0000, 1'b0};
        vecs[5] = '{14'd0,     16'h0000, 4'b1110, 1'b0};
        vecs[6] = '{14'd100,   16'h0100, 4'b1000, 1'b0};
        vecs[7] = '{14'd10000, 16'hFFFF, 4'b0000, 1'b1};
        vecs[8] = '{14'd50,    16'h0050, 4'b1100, 1'b0};
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
        model_reset();

        // first frame after reset: idx 0 shows "0", others blanked
        repeat (40) step(0, 0);

        // table-driven loads, each observed over one full frame
        for (int v = 0; v < 9; v++) begin
            step(1, int'(vecs[v].val));
            repeat (15) step(0, 0);
            cap_en = 1;
            repeat (4 * TD) step(0, 0);
            cap_en = 0;
            chk("tbl_bcd", int'(obs_bcd), int'(vecs[v].bcd));
            chk("tbl_blank", int'(obs_blank), int'(vecs[v].blank));
            chk("tbl_digit", int'(obs_dig), 16'h7BDE);
            chk("tbl_ovf", int'(o_ovf), int'(vecs[v].ovf));
        end

        // busy handshake: 77 during busy is dropped, 77 at A+15 is accepted
        busy_cnt = 0;
        step(1, 42);
        bcnt_en = 1;
        repeat (4) step(0, 0);
        step(1, 77);
        repeat (9) step(0, 0);
        bcnt_en = 0;
        chk("busy_len", busy_cnt, 14);
        step(1, 77);
        repeat (50) step(0, 0);

        // asynchronous reset mid-frame while a non-zero digit is shown
        step(1, 1234);
        repeat (20) step(0, 0);
        for (int k = 0; k < 40 && (cyc % (4 * TD)) != TD + 4; k++) step(0, 0);
        chk("pre_rst_bcd", int'(o_bcd), 3);
        do_reset();
        repeat (40) step(0, 0);

        // reset at A+7 of a conversion aborts it
        step(1, 1234);
        repeat (50) step(0, 0);
        step(1, 5678);
        repeat (6) step(0, 0);
        do_reset();
        repeat (48) step(0, 0);

        // randomized loads, including requests while busy and out-of-range values
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 11) == 0)
                step(1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 16383))
                                                    : int'($urandom_range(0, 9999)));
            else
                step(0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Sequences a single BCD-to-7-segment font decoder across a 4-digit common-anode FND. Accepts a 14-bit binary value over a load handshake and converts it to four BCD digits with a sequential shift-add-3 converter. Time-multiplexes the digits: a prescaled slot counter selects one digit at a time, inserts an anti-ghosting blank gap, and suppresses leading zeros. Sits between the application counter/adder logic and the font decoder; its `o_bcd` and `o_blank` outputs drive the decoder's value and enable (blank) inputs.

## Interface
- `TICK_DIV`, default 100000: clock cycles per digit slot; legal range ≥ 2.
- `GAP_CYCLES`, default 1000: blank cycles at the start of each slot; legal range 0 ≤ `GAP_CYCLES` < `TICK_DIV`.
- `i_clk` in 1: the single clock; all state changes on the rising edge.
- `i_reset` in 1: reset, asynchronous and active-high.
- `i_value` in 14: binary value to display; only 0..9999 is displayable.
- `i_load` in 1: load request; sampled only while `o_busy` = 0.
- `o_busy` in/out: out 1: conversion in progress; loads are ignored while it is high.
- `o_ovf` out 1: the last accepted value was > 9999.
- `o_digit` out 4: digit select, active-low; bit 0 is the ones digit and bit 3 the thousands digit.
- `o_bcd` out 4: BCD code for the selected digit, to the decoder value input.
- `o_blank` out 1: 1 blanks the decoder (its enable input).

## Operation
- **Load**
  - Accept when `i_load` = 1 and `o_busy` = 0.
  - Capture `i_value` and set `o_busy` = 1 on the next edge.
  - `i_load` while busy is dropped; there is no queueing.
- **Conversion**
  - Double-dabble, one input bit per cycle, 14 iterations, MSB first.
  - Before each shift, add 3 to every BCD nibble ≥ 5.
  - 16-bit BCD accumulator, 4 nibbles.
  - On the final iteration, the display digit register (4×4) and `o_ovf` update atomically, and `o_busy` clears.
  - The old digits remain displayed for the whole conversion.
- **Overflow**
  - If the captured value is > 9999, `o_ovf` = 1 and all four stored digits = 4'hF.
  - The decoder blanks 4'hF, so the display goes fully dark.
  - `o_ovf` clears on the next in-range conversion.
- **Scan FSM** (states `GAP`, `ON`)
  - Prescaler counts 0..`TICK_DIV`−1 per slot.
  - `GAP` is active for prescaler < `GAP_CYCLES`; `ON` for the rest of the slot.
  - In `GAP`: `o_digit` = 4'b1111 and `o_blank` = 1.
  - In `ON`: `o_digit` = active-low one-hot of the 2-bit digit index (idx 0 → 4'b1110, idx 3 → 4'b0111), `o_bcd` = stored digit[idx], and `o_blank` = suppress[idx].
  - At prescaler wrap, idx increments modulo 4 (3 → 0) and the FSM returns to `GAP`.
  - If `GAP_CYCLES` = 0, `GAP` is never entered.
- **Leading-zero suppression**
  - suppress[k] = 1 when digit k and all higher digits are 0, for k = 3..1.
  - The ones digit is never suppressed, so value 0 shows "0".
  - Suppression is not applied in overflow.
- **Reset**
  - All outputs: `o_digit` = 4'b1111, `o_bcd` = 0, `o_blank` = 1, `o_busy` = 0, `o_ovf` = 0.
  - Internal state: stored digits = 0, idx = 0, prescaler = 0, FSM in `GAP`.
  - Reset mid-conversion aborts it; the result is discarded.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Load latency:
  - Accept edge at cycle A.
  - `o_busy` = 1 from A+1 through A+14.
  - New digits and `o_ovf` are visible at A+15, with `o_busy` = 0 in the same cycle.
  - A new load is accepted at A+15 at the earliest.
- `o_bcd` and `o_blank` follow digit updates within 1 cycle during `ON`; a digit change mid-slot is shown immediately.
- Slot period = `TICK_DIV` cycles; frame = 4×`TICK_DIV` cycles.
- After reset release, the first `ON` begins at cycle `GAP_CYCLES`, with idx 0.
- Scan and conversion run concurrently and independently.

## Structure
- A shared package `fnd_pkg` holds:
  - `DIGIT_OFF` = 4'b1111
  - `BCD_BLANK` = 4'hF
  - `MAX_DISPLAY` = 9999
  - the scan state enum (`GAP`, `ON`)
  - the digit-index typedef (2-bit)
- One sub-module: `bin_to_bcd_seq`. It is the 14-bit sequential double-dabble converter with a start/busy/done interface and a 16-bit BCD output.
- `fnd_scan_controller` holds the load handshake, the digit register, the overflow logic, the prescaler, the scan FSM and the suppression logic.

## Test plan
All scenarios use `TICK_DIV` = 8 and `GAP_CYCLES` = 2.
1. **Reset:** assert `i_reset` mid-frame → all outputs go to reset values asynchronously. After release, the first `ON` slot shows idx 0 with `o_digit` = 4'b1110, `o_bcd` = 0 and `o_blank` = 0; slots 1–3 are blanked.
2. **Load 1234:** `o_busy` is high for exactly 14 cycles. From A+15, slots 0..3 output `o_bcd` = 4, 3, 2, 1 with `o_digit` = 1110, 1101, 1011, 0111, and each slot begins with 2 cycles of 4'b1111.
3. **Load 7:** slot 0 shows `o_bcd` = 7 with `o_blank` = 0; slots 1..3 have `o_blank` = 1. Then load 1005: all slots are unblanked, showing 5, 0, 0, 1.
4. **Load 12000:** `o_ovf` = 1 and all slots have `o_bcd` = 4'hF. Then load 9999: `o_ovf` = 0 and all digits show 9.
5. **Busy handshake:** pulse `i_load` with 42 at A and with 77 at A+5 → 77 is ignored and 42 is displayed. A load of 77 at A+15 is accepted.
6. **Reset mid-conversion:** reset at A+7 of a load of 5678, with 1234 previously shown → after release the digits are all 0, `o_busy` = 0, and no update occurs at A+15.
